// File: rtl/life_solver_wrap_if.sv
// Control handshake and arena B-port signals of the Game-of-Life solver.
interface life_solver_wrap_if #(
    parameter int ARENA_WIDTH   = 10,
    parameter int ROW_SEL_WIDTH = 10,
    parameter int COUNT_WIDTH   = 32
);
    logic                     start;
    logic [COUNT_WIDTH-1:0]   generations_count;
    logic                     ready;
    logic [1:0]               status;
    logic [COUNT_WIDTH-1:0]   generations_done;
    logic [ROW_SEL_WIDTH-1:0] arena_row_select;
    logic [ARENA_WIDTH-1:0]   arena_columns;
    logic [ARENA_WIDTH-1:0]   arena_columns_new;
    logic                     arena_columns_write;

    // slave is the solver; master is the control logic plus the arena RAM
    modport slave (
        input  start, generations_count, arena_columns,
        output ready, status, generations_done,
               arena_row_select, arena_columns_new, arena_columns_write
    );
    modport master (
        output start, generations_count, arena_columns,
        input  ready, status, generations_done,
               arena_row_select, arena_columns_new, arena_columns_write
    );
endinterface

// File: rtl/life_solver_wrap.sv
// In-place Game-of-Life solver over the arena RAM B port, optional toroidal edges,
// early stop on still-life or extinction.
module life_solver_wrap #(
    parameter int ARENA_WIDTH   = 10,
    parameter int ARENA_HEIGHT  = 10,
    parameter int ROW_SEL_WIDTH = 10,
    parameter int COUNT_WIDTH   = 32,
    parameter int WRAP          = 0
) (
    input  logic              clk,
    input  logic              reset,
    life_solver_wrap_if.slave bus
);
    localparam bit                       WRAP_EN    = (WRAP != 0);
    localparam logic [ROW_SEL_WIDTH-1:0] ROW_ONE    = ROW_SEL_WIDTH'(1);
    localparam logic [ROW_SEL_WIDTH-1:0] LAST_ROW   = ROW_SEL_WIDTH'(ARENA_HEIGHT - 1);
    localparam logic [ROW_SEL_WIDTH-1:0] PENULT_ROW = ROW_SEL_WIDTH'(ARENA_HEIGHT - 2);
    localparam logic [1:0] ST_COMPLETED = 2'b00;
    localparam logic [1:0] ST_STABLE    = 2'b01;
    localparam logic [1:0] ST_EXTINCT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_P0, S_P1, S_P2, S_WR, S_RD, S_HOLD, S_DONE
    } state_t;

    state_t                   state, state_nx;
    logic [ROW_SEL_WIDTH-1:0] row, row_nx;
    logic [COUNT_WIDTH-1:0]   gens_req, gens_req_nx;
    logic [COUNT_WIDTH-1:0]   gens_done, gens_done_nx;
    logic [1:0]               status, status_nx;
    logic                     changed, changed_nx;
    logic                     alive, alive_nx;

    logic [ARENA_WIDTH-1:0]   prev_row, cur_row, row0_save;
    logic [ARENA_WIDTH-1:0]   next_row, new_row;

    // Bit c of the result holds neighbour cell c+1 (up) or c-1 (dn) of the same row.
    function automatic logic [ARENA_WIDTH-1:0] shift_up(input logic [ARENA_WIDTH-1:0] r);
        return {WRAP_EN & r[0], r[ARENA_WIDTH-1:1]};
    endfunction

    function automatic logic [ARENA_WIDTH-1:0] shift_dn(input logic [ARENA_WIDTH-1:0] r);
        return {r[ARENA_WIDTH-2:0], WRAP_EN & r[ARENA_WIDTH-1]};
    endfunction

    function automatic logic [ARENA_WIDTH-1:0] life_step(
        input logic [ARENA_WIDTH-1:0] prv,
        input logic [ARENA_WIDTH-1:0] cur,
        input logic [ARENA_WIDTH-1:0] nxt
    );
        logic [7:0][ARENA_WIDTH-1:0] nb;
        logic [ARENA_WIDTH-1:0]      res;
        logic [3:0]                  sum;
        nb[0] = shift_up(prv);
        nb[1] = prv;
        nb[2] = shift_dn(prv);
        nb[3] = shift_up(cur);
        nb[4] = shift_dn(cur);
        nb[5] = shift_up(nxt);
        nb[6] = nxt;
        nb[7] = shift_dn(nxt);
        res   = '0;
        for (int c = 0; c < ARENA_WIDTH; c++) begin
            sum = '0;
            for (int k = 0; k < 8; k++) begin
                sum = sum + {3'b000, nb[k][c]};
            end
            res[c] = (sum == 4'd3) | (cur[c] & (sum == 4'd2));
        end
        return res;
    endfunction

    // The bottom row's lower neighbour is the saved old row 0 (torus) or dead cells.
    assign next_row = (row == LAST_ROW) ? (WRAP_EN ? row0_save : '0) : bus.arena_columns;
    assign new_row  = life_step(prev_row, cur_row, next_row);

    assign bus.ready               = (state == S_IDLE);
    assign bus.status              = status;
    assign bus.generations_done    = gens_done;
    assign bus.arena_columns_new   = (state == S_WR) ? new_row : '0;
    assign bus.arena_columns_write = (state == S_WR) && !reset;

    always_comb begin
        bus.arena_row_select = '0;
        case (state)
            S_P0:    bus.arena_row_select = LAST_ROW;
            S_P1:    bus.arena_row_select = '0;
            S_P2:    bus.arena_row_select = ROW_ONE;
            S_WR:    bus.arena_row_select = row;
            S_RD:    bus.arena_row_select = row + ROW_ONE;
            S_HOLD:  bus.arena_row_select = row - ROW_ONE;
            default: bus.arena_row_select = '0;
        endcase
    end

    always_comb begin
        state_nx     = state;
        row_nx       = row;
        gens_req_nx  = gens_req;
        gens_done_nx = gens_done;
        status_nx    = status;
        changed_nx   = changed;
        alive_nx     = alive;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    gens_req_nx  = bus.generations_count;
                    gens_done_nx = '0;
                    status_nx    = ST_COMPLETED;
                    state_nx     = (bus.generations_count == '0) ? S_DONE : S_P0;
                end
            end
            S_P0: begin
                changed_nx = 1'b0;
                alive_nx   = 1'b0;
                row_nx     = '0;
                state_nx   = S_P1;
            end
            S_P1: state_nx = S_P2;
            S_P2: state_nx = S_WR;
            S_WR: begin
                changed_nx = changed | (new_row != cur_row);
                alive_nx   = alive | (new_row != '0);
                row_nx     = row + ROW_ONE;
                if (row == LAST_ROW) begin
                    gens_done_nx = gens_done + COUNT_WIDTH'(1);
                    if (!alive_nx) begin
                        status_nx = ST_EXTINCT;
                        state_nx  = S_DONE;
                    end else if (!changed_nx) begin
                        status_nx = ST_STABLE;
                        state_nx  = S_DONE;
                    end else if (gens_done_nx == gens_req) begin
                        status_nx = ST_COMPLETED;
                        state_nx  = S_DONE;
                    end else begin
                        state_nx  = S_P0;
                    end
                end else if (row == PENULT_ROW) begin
                    state_nx = S_HOLD;
                end else begin
                    state_nx = S_RD;
                end
            end
            S_RD, S_HOLD: state_nx = S_WR;
            S_DONE:       state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            row       <= '0;
            gens_req  <= '0;
            gens_done <= '0;
            status    <= ST_COMPLETED;
            changed   <= 1'b0;
            alive     <= 1'b0;
        end else begin
            state     <= state_nx;
            row       <= row_nx;
            gens_req  <= gens_req_nx;
            gens_done <= gens_done_nx;
            status    <= status_nx;
            changed   <= changed_nx;
            alive     <= alive_nx;
        end
    end

    // Row window: prev/cur/saved row 0; data only, never reset.
    always_ff @(posedge clk) begin
        case (state)
            S_P1: prev_row <= WRAP_EN ? bus.arena_columns : '0;
            S_P2: begin
                cur_row   <= bus.arena_columns;
                row0_save <= bus.arena_columns;
            end
            S_WR: begin
                prev_row <= cur_row;
                cur_row  <= next_row;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_life_solver_wrap.sv
// Directed bench: a WRAP=0 and a WRAP=1 solver share stimulus, each with its own arena RAM.
module tb_life_solver_wrap;
    localparam int AW  = 10;
    localparam int AH  = 10;
    localparam int RSW = 10;
    localparam int CW  = 32;

    typedef logic [AH-1:0][AW-1:0] arena_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    life_solver_wrap_if #(.ARENA_WIDTH(AW), .ROW_SEL_WIDTH(RSW), .COUNT_WIDTH(CW)) b0 ();
    life_solver_wrap_if #(.ARENA_WIDTH(AW), .ROW_SEL_WIDTH(RSW), .COUNT_WIDTH(CW)) b1 ();

    life_solver_wrap #(.ARENA_WIDTH(AW), .ARENA_HEIGHT(AH), .ROW_SEL_WIDTH(RSW),
                       .COUNT_WIDTH(CW), .WRAP(0))
        dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    life_solver_wrap #(.ARENA_WIDTH(AW), .ARENA_HEIGHT(AH), .ROW_SEL_WIDTH(RSW),
                       .COUNT_WIDTH(CW), .WRAP(1))
        dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    logic [AW-1:0] mem0 [AH];
    logic [AW-1:0] mem1 [AH];
    logic          ld_en = 1'b0;
    int            ld_addr = 0;
    logic [AW-1:0] ld_data = '0;
    int            wr0 = 0, wr1 = 0, wr_in_reset = 0;
    int            n_cmp = 0, n_bad = 0;

    // Arena RAMs: synchronous read, write at posedge; bench loads through the same process.
    always @(posedge clk) begin
        if (ld_en) begin
            mem0[ld_addr] <= ld_data;
            mem1[ld_addr] <= ld_data;
        end else begin
            if (b0.arena_columns_write) mem0[int'(b0.arena_row_select)] <= b0.arena_columns_new;
            if (b1.arena_columns_write) mem1[int'(b1.arena_row_select)] <= b1.arena_columns_new;
        end
        b0.arena_columns <= mem0[int'(b0.arena_row_select)];
        b1.arena_columns <= mem1[int'(b1.arena_row_select)];
        if (b0.arena_columns_write) wr0 <= wr0 + 1;
        if (b1.arena_columns_write) wr1 <= wr1 + 1;
        if (reset && (b0.arena_columns_write || b1.arena_columns_write)) wr_in_reset <= wr_in_reset + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_arena(input string tag, input int which, input arena_t e);
        logic [AW-1:0] obs;
        for (int r = 0; r < AH; r++) begin
            obs = (which == 0) ? mem0[r] : mem1[r];
            chk($sformatf("%s row%0d", tag, r), {54'd0, obs}, {54'd0, e[r]});
        end
    endtask

    task automatic chk_result(input string tag, input int which, input int exp_done,
                              input logic [1:0] exp_status);
        if (which == 0) begin
            chk({tag, " done"}, {32'd0, b0.generations_done}, 64'(exp_done));
            chk({tag, " status"}, {62'd0, b0.status}, {62'd0, exp_status});
        end else begin
            chk({tag, " done"}, {32'd0, b1.generations_done}, 64'(exp_done));
            chk({tag, " status"}, {62'd0, b1.status}, {62'd0, exp_status});
        end
    endtask

    task automatic load(input arena_t p);
        for (int r = 0; r < AH; r++) begin
            ld_en = 1'b1; ld_addr = r; ld_data = p[r];
            @(negedge clk);
        end
        ld_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_start(input logic s, input logic [CW-1:0] g);
        b0.start = s; b1.start = s;
        b0.generations_count = g; b1.generations_count = g;
    endtask

    // Starts both solvers; lat0 = edges from the start-sampling edge until dut0 ready.
    // A second start with count 7 is pulsed at cycle poke_at (0 disables it).
    task automatic run(input logic [CW-1:0] g, input int poke_at, output int lat0);
        bit finished = 1'b0;
        lat0 = -1;
        set_start(1'b1, g);
        @(negedge clk);
        set_start(1'b0, g);
        for (int k = 1; k <= 5000; k++) begin
            if (lat0 < 0 && b0.ready) lat0 = k;
            if (b0.ready && b1.ready) begin
                finished = 1'b1;
                break;
            end
            if (k == poke_at) set_start(1'b1, CW'(7));
            else              set_start(1'b0, g);
            @(negedge clk);
        end
        set_start(1'b0, g);
        if (!finished) chk("run timeout", 64'd0, 64'd1);
    endtask

    arena_t pat, expv;
    int     lat, w0_before;

    initial begin
        reset = 1'b1;
        set_start(1'b0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("reset ready",  {63'd0, b0.ready}, 64'd1);
        chk("reset status", {62'd0, b0.status}, 64'd0);
        chk("reset done",   {32'd0, b0.generations_done}, 64'd0);
        chk("reset rowsel", {54'd0, b0.arena_row_select}, 64'd0);
        chk("reset colnew", {54'd0, b0.arena_columns_new}, 64'd0);
        chk("reset write",  {63'd0, b0.arena_columns_write}, 64'd0);

        // Horizontal blinker becomes vertical after one generation
        pat = '0; pat[4] = 10'b0000111000;
        load(pat);
        run(CW'(1), 0, lat);
        expv = '0; expv[3] = 10'b0000010000; expv[4] = 10'b0000010000; expv[5] = 10'b0000010000;
        chk_arena("blinker w0", 0, expv);
        chk_arena("blinker w1", 1, expv);
        chk_result("blinker w0", 0, 1, 2'b00);
        chk("blinker latency", 64'(lat), 64'd24);

        // Block is a still life: stops after the first generation
        pat = '0; pat[4] = 10'b0000110000; pat[5] = 10'b0000110000;
        load(pat);
        run(CW'(10), 0, lat);
        chk_arena("block", 0, pat);
        chk_result("block", 0, 1, 2'b01);

        // Lone cell dies; empty arena is extinct rather than stable
        pat = '0; pat[5] = 10'b0000100000;
        load(pat);
        run(CW'(5), 0, lat);
        expv = '0;
        chk_arena("lone cell", 0, expv);
        chk_result("lone cell", 0, 1, 2'b10);
        pat = '0;
        load(pat);
        run(CW'(3), 0, lat);
        chk_result("empty w0", 0, 1, 2'b10);
        chk_result("empty w1", 1, 1, 2'b10);

        // Zero generations: no RAM writes, ready back two edges after start
        w0_before = wr0;
        run(CW'(0), 0, lat);
        chk("gens0 writes", 64'(wr0), 64'(w0_before));
        chk("gens0 latency", 64'(lat), 64'd2);
        chk_result("gens0", 0, 0, 2'b00);

        // Edge blinker across columns 9,0,1 on the torus
        pat = '0; pat[5] = 10'b1000000011;
        load(pat);
        run(CW'(1), 0, lat);
        expv = '0; expv[4] = 10'b0000000001; expv[5] = 10'b0000000001; expv[6] = 10'b0000000001;
        chk_arena("wrap blinker", 1, expv);
        chk_result("wrap blinker", 1, 1, 2'b00);

        // Vertical blinker on column 0: oscillates on the torus, dies in two gens with dead edges
        pat = expv;
        load(pat);
        run(CW'(10), 0, lat);
        chk_arena("col0 blinker w1", 1, pat);
        chk_result("col0 blinker w1", 1, 10, 2'b00);
        chk_arena("col0 blinker w0", 0, '0);
        chk_result("col0 blinker w0", 0, 2, 2'b10);

        // Glider returns to its start after 40 generations on a 10x10 torus
        pat = '0; pat[0] = 10'b0000000010; pat[1] = 10'b0000000100; pat[2] = 10'b0000000111;
        load(pat);
        run(CW'(40), 0, lat);
        chk_arena("glider", 1, pat);
        chk_result("glider", 1, 40, 2'b00);

        // Start pulsed while busy is ignored
        pat = '0; pat[4] = 10'b0000111000;
        load(pat);
        run(CW'(3), 10, lat);
        expv = '0; expv[3] = 10'b0000010000; expv[4] = 10'b0000010000; expv[5] = 10'b0000010000;
        chk_arena("busy start", 0, expv);
        chk_result("busy start", 0, 3, 2'b00);

        // Reset landing on a write cycle (row 1 of generation 2) suppresses that write
        load(pat);
        set_start(1'b1, CW'(10));
        @(negedge clk);
        set_start(1'b0, CW'(10));
        repeat (27) @(negedge clk);
        chk("pre-reset write", {63'd0, b0.arena_columns_write}, 64'd1);
        chk("pre-reset done", {32'd0, b0.generations_done}, 64'd1);
        reset = 1'b1;
        #1;
        chk("reset gates write w0", {63'd0, b0.arena_columns_write}, 64'd0);
        chk("reset gates write w1", {63'd0, b1.arena_columns_write}, 64'd0);
        w0_before = wr0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset ready",  {63'd0, b0.ready}, 64'd1);
        chk("mid reset status", {62'd0, b0.status}, 64'd0);
        chk("mid reset done",   {32'd0, b0.generations_done}, 64'd0);
        repeat (5) @(negedge clk);
        chk("no writes after reset", 64'(wr0), 64'(w0_before));

        // Reset seven cycles after start, then a fresh run
        load(pat);
        set_start(1'b1, CW'(10));
        @(negedge clk);
        set_start(1'b0, CW'(10));
        repeat (6) @(negedge clk);
        reset = 1'b1;
        w0_before = wr0;
        @(negedge clk);
        reset = 1'b0;
        chk("reset7 ready",  {63'd0, b0.ready}, 64'd1);
        chk("reset7 status", {62'd0, b0.status}, 64'd0);
        chk("reset7 done",   {32'd0, b0.generations_done}, 64'd0);
        repeat (5) @(negedge clk);
        chk("reset7 no writes", 64'(wr0), 64'(w0_before));
        chk("writes during reset", 64'(wr_in_reset), 64'd0);

        load(pat);
        run(CW'(1), 0, lat);
        chk_arena("after reset", 0, expv);
        chk_result("after reset", 0, 1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
